gstdmasnd: RTL

Parametrised DMA sound playback engine for the STE/Falcon-class shifter path. It buffers sound words fetched by the MCU's DMA sound slots (`SLOAD_N` strobes with data on `MDIN`) in a configurable-depth FIFO. It replays them at one of four base-derived sample rates in 8-bit or 16-bit, mono or stereo formats, producing signed left-justified audio words. It adds what the original shifter sound path lacks: 16-bit formats, true full-depth FIFO, level/overflow/underrun reporting and a flush-on-disable.

---
 rtl/gstdmasnd.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/gstdmasnd.sv
// DMA sound playback engine: DMA-fed sample FIFO, base-rate tick generator,
// 8/16-bit mono/stereo unpacking to left-justified signed audio words.
module gstdmasnd #(
  parameter int FIFO_AW  = 3,
  parameter int BASE_DIV = 640,
  parameter int OUT_W    = 16,
  parameter int REQ_FREE = 2
) (
  input  logic             clk32,
  input  logic             res,
  input  logic             enable,
  input  logic [1:0]       cfg_rate,
  input  logic [1:0]       cfg_fmt,
  input  logic             SLOAD_N,
  input  logic [15:0]      MDIN,
  input  logic             clr_flags,
  output logic             SREQ,
  output logic [OUT_W-1:0] audio_left,
  output logic [OUT_W-1:0] audio_right,
  output logic             sample_strobe,
  output logic [FIFO_AW:0] level,
  output logic             underrun,
  output logic             overflow
);

  localparam int D  = 2**FIFO_AW;
  localparam int BW = $clog2(BASE_DIV);
  localparam logic [FIFO_AW:0] DL = (FIFO_AW+1)'(D);
  localparam logic [FIFO_AW:0] RF = (FIFO_AW+1)'(REQ_FREE);

  logic [15:0]        mem [D];
  logic [FIFO_AW:0]   wp, rp;
  logic [FIFO_AW-1:0] ra1;
  logic [BW-1:0]      bcnt;
  logic [2:0]         acnt;
  logic               sload_d;
  logic               tick_q;
  logic               bytesel;

  logic               wr_req, full, wr, ovf_set;
  logic               base_en, rate_ok;
  logic [FIFO_AW:0]   need, pops;
  logic [15:0]        w0, w1;
  logic [7:0]         mbyte;
  logic [OUT_W-1:0]   nxt_l, nxt_r;
  logic               nxt_bs, strobe_n, und_set;

  function automatic logic [OUT_W-1:0] al8(input logic [7:0] b);
    logic [OUT_W-1:0] t;
    t = '0;
    t[OUT_W-1 -: 8] = b;
    return t;
  endfunction

  function automatic logic [OUT_W-1:0] al16(input logic [15:0] w);
    logic [OUT_W-1:0] t;
    t = '0;
    t[OUT_W-1 -: 16] = w;
    return t;
  endfunction

  assign level   = wp - rp;
  assign full    = (level == DL);
  assign wr_req  = enable && sload_d && !SLOAD_N;
  assign wr      = wr_req && !full;
  assign ovf_set = wr_req && full;
  assign base_en = (bcnt == BW'(BASE_DIV-1));
  assign ra1     = rp[FIFO_AW-1:0] + FIFO_AW'(1);
  assign w0      = mem[rp[FIFO_AW-1:0]];
  assign w1      = mem[ra1];
  assign need    = (cfg_fmt == 2'b10) ? (FIFO_AW+1)'(2) : (FIFO_AW+1)'(1);
  assign mbyte   = bytesel ? w0[7:0] : w0[15:8];

  always_comb begin
    rate_ok = 1'b0;
    unique case (cfg_rate)
      2'b11: rate_ok = 1'b1;
      2'b10: rate_ok = (acnt[0] == 1'b0);
      2'b01: rate_ok = (acnt[1:0] == 2'b00);
      2'b00: rate_ok = (acnt == 3'd0);
      default: rate_ok = 1'b0;
    endcase
  end

  always_comb begin
    pops     = '0;
    nxt_l    = audio_left;
    nxt_r    = audio_right;
    nxt_bs   = bytesel;
    strobe_n = 1'b0;
    und_set  = 1'b0;
    if (tick_q) begin
      if (level < need) begin
        und_set = 1'b1;
      end else begin
        strobe_n = 1'b1;
        unique case (cfg_fmt)
          2'b00: begin
            nxt_l = al8(w0[15:8]);
            nxt_r = al8(w0[7:0]);
            pops  = (FIFO_AW+1)'(1);
          end
          2'b01: begin
            nxt_l  = al8(mbyte);
            nxt_r  = al8(mbyte);
            nxt_bs = !bytesel;
            pops   = bytesel ? (FIFO_AW+1)'(1) : '0;
          end
          2'b10: begin
            nxt_l = al16(w0);
            nxt_r = al16(w1);
            pops  = (FIFO_AW+1)'(2);
          end
          default: begin
            nxt_l = al16(w0);
            nxt_r = al16(w0);
            pops  = (FIFO_AW+1)'(1);
          end
        endcase
      end
    end
    if (cfg_fmt != 2'b01) nxt_bs = 1'b0;
  end

  // Storage array is not reset; pointers alone define its contents.
  always_ff @(posedge clk32) begin
    if (wr) mem[wp[FIFO_AW-1:0]] <= MDIN;
  end

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      wp            <= '0;
      rp            <= '0;
      bcnt          <= '0;
      acnt          <= '0;
      sload_d       <= 1'b1;
      tick_q        <= 1'b0;
      bytesel       <= 1'b0;
      audio_left    <= '0;
      audio_right   <= '0;
      sample_strobe <= 1'b0;
      SREQ          <= 1'b0;
    end else if (!enable) begin
      wp            <= '0;
      rp            <= '0;
      bcnt          <= '0;
      acnt          <= '0;
      sload_d       <= SLOAD_N;
      tick_q        <= 1'b0;
      bytesel       <= 1'b0;
      audio_left    <= '0;
      audio_right   <= '0;
      sample_strobe <= 1'b0;
      SREQ          <= 1'b0;
    end else begin
      sload_d       <= SLOAD_N;
      if (wr) wp    <= wp + (FIFO_AW+1)'(1);
      rp            <= rp + pops;
      bcnt          <= base_en ? '0 : bcnt + BW'(1);
      if (base_en) acnt <= acnt + 3'd1;
      tick_q        <= base_en && rate_ok;
      bytesel       <= nxt_bs;
      audio_left    <= nxt_l;
      audio_right   <= nxt_r;
      sample_strobe <= strobe_n;
      SREQ          <= ((DL - level) >= RF);
    end
  end

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (ovf_set)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (und_set)        underrun <= 1'b1;
      else if (clr_flags) underrun <= 1'b0;
    end
  end

endmodule
